// File: rtl/mc_controller_pkg.sv
// Shared types and codes for the multicycle RV32 controller.
// Optional feature macro MC_CTRL_BNE_EN (bne support) is consumed in mc_controller.sv.
package mc_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_ADD = 3'b000;
    localparam logic [2:0] ALUCTL_SUB = 3'b001;
    localparam logic [2:0] ALUCTL_AND = 3'b010;
    localparam logic [2:0] ALUCTL_OR  = 3'b011;
    localparam logic [2:0] ALUCTL_XOR = 3'b100;
    localparam logic [2:0] ALUCTL_SLT = 3'b101;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    function automatic logic [1:0] imm_src_dec(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src_dec = IMM_S;
            OP_BEQ:  imm_src_dec = IMM_B;
            OP_JAL:  imm_src_dec = IMM_J;
            default: imm_src_dec = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Instruction fields in, datapath controls out. master = controller, slave = datapath.
interface mc_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic       AdrSrc;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state_dbg;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state_dbg
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, state_dbg
    );
endinterface

// File: rtl/mc_controller_alu_dec.sv
// ALU operation decode from ALUOp and instruction function bits.
module alu_dec
    import mc_controller_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);

    // funct3 000 is sub only for R-type with funct7[5] set; I-type addi ignores funct7
    always_comb begin
        o_alu_control = ALUCTL_ADD;
        case (i_alu_op)
            ALUOP_ADD: o_alu_control = ALUCTL_ADD;
            ALUOP_SUB: o_alu_control = ALUCTL_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALUCTL_SUB : ALUCTL_ADD;
                    3'b010:  o_alu_control = ALUCTL_SLT;
                    3'b100:  o_alu_control = ALUCTL_XOR;
                    3'b110:  o_alu_control = ALUCTL_OR;
                    3'b111:  o_alu_control = ALUCTL_AND;
                    default: o_alu_control = ALUCTL_ADD;
                endcase
            end
            default: o_alu_control = ALUCTL_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore FSM controller for the 32-bit multicycle RV32 datapath.
// Define MC_CTRL_BNE_EN to let the branch state also resolve bne via funct3[0].
module mc_controller
    import mc_controller_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mc_controller_if.master bus
);

    state_t     r_state;
    state_t     w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic       w_taken;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [2:0] w_alu_control;

    // State register; reset lands in FETCH immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        w_next       = S_FETCH;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = RES_ALUOUT;
        w_alu_src_a  = SRCA_PC;
        w_alu_src_b  = SRCB_RS2;
        w_alu_op     = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_pc_update  = 1'b1;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RES_ALURESULT;
                w_next       = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXECUTER;
                    OP_ITYPE:     w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
                w_next      = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
                w_next    = S_MEMWB;
            end
            S_MEMWB: begin
                w_result_src = RES_DATA;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXECUTER: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_RS2;
                w_alu_op    = ALUOP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_EXECUTEI: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_IMM;
                w_alu_op    = ALUOP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a = SRCA_RS1;
                w_alu_src_b = SRCB_RS2;
                w_alu_op    = ALUOP_SUB;
                w_branch    = 1'b1;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                w_alu_src_a = SRCA_OLDPC;
                w_alu_src_b = SRCB_FOUR;
                w_pc_update = 1'b1;
                w_next      = S_ALUWB;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Branch condition from the ALU equality flag
    always_comb begin
`ifdef MC_CTRL_BNE_EN
        if (bus.funct3[0]) begin
            w_taken = ~bus.Zero;
        end else begin
            w_taken = bus.Zero;
        end
`else
        w_taken = bus.Zero;
`endif
    end

    alu_dec u_alu_dec (
        .i_alu_op      (w_alu_op),
        .i_funct3      (bus.funct3),
        .i_op5         (bus.op[5]),
        .i_funct7b5    (bus.funct7b5),
        .o_alu_control (w_alu_control)
    );

    // Write enables are held off for the whole reset window
    assign bus.PCWrite    = rst_n & (w_pc_update | (w_branch & w_taken));
    assign bus.IRWrite    = rst_n & w_ir_write;
    assign bus.MemWrite   = rst_n & w_mem_write;
    assign bus.RegWrite   = rst_n & w_reg_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ImmSrc     = imm_src_dec(bus.op);
    assign bus.ALUControl = w_alu_control;
    assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
module tb_mc_controller;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;
    logic exp_bne;

    mc_controller_if bus ();

    mc_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [3:0] st, input logic pcw,
                              input logic irw, input logic mw, input logic rw);
        chk({tag, ".state"}, {28'd0, bus.state_dbg}, {28'd0, st});
        chk({tag, ".PCWrite"}, {31'd0, bus.PCWrite}, {31'd0, pcw});
        chk({tag, ".IRWrite"}, {31'd0, bus.IRWrite}, {31'd0, irw});
        chk({tag, ".MemWrite"}, {31'd0, bus.MemWrite}, {31'd0, mw});
        chk({tag, ".RegWrite"}, {31'd0, bus.RegWrite}, {31'd0, rw});
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic z);
        bus.op       = op;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.Zero     = z;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
`ifdef MC_CTRL_BNE_EN
        exp_bne = 1'b1;
`else
        exp_bne = 1'b0;
`endif
        rst_n = 1'b0;
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        #2;
        expect_cyc("rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.ALUSrcB", {30'd0, bus.ALUSrcB}, 32'd2);
        chk("rst.ResultSrc", {30'd0, bus.ResultSrc}, 32'd2);
        chk("rst.AdrSrc", {31'd0, bus.AdrSrc}, 32'd0);

        // lw: FETCH DECODE MEMADR MEMREAD MEMWB FETCH
        @(negedge clk);
        rst_n = 1'b1;
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        expect_cyc("lw.fetch", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        expect_cyc("lw.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw.decode.srcA", {30'd0, bus.ALUSrcA}, 32'd1);
        chk("lw.decode.srcB", {30'd0, bus.ALUSrcB}, 32'd1);
        step();
        expect_cyc("lw.memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw.memadr.srcA", {30'd0, bus.ALUSrcA}, 32'd2);
        step();
        expect_cyc("lw.memread", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("lw.memread.adr", {31'd0, bus.AdrSrc}, 32'd1);
        step();
        expect_cyc("lw.memwb", 4'd4, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lw.memwb.res", {30'd0, bus.ResultSrc}, 32'd1);
        step();

        // sw: MemWrite one cycle, ImmSrc=S
        set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
        expect_cyc("sw.fetch", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("sw.imm", {30'd0, bus.ImmSrc}, 32'd1);
        step();
        expect_cyc("sw.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_cyc("sw.memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_cyc("sw.memwrite", 4'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sw.memwrite.adr", {31'd0, bus.AdrSrc}, 32'd1);
        step();
        expect_cyc("sw.after", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // R-type sub
        set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
        chk("sub.fetch.aluctl", {29'd0, bus.ALUControl}, 32'd0);
        step();
        expect_cyc("sub.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_cyc("sub.exec", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sub.aluctl", {29'd0, bus.ALUControl}, 32'd1);
        chk("sub.srcB", {30'd0, bus.ALUSrcB}, 32'd0);
        step();
        expect_cyc("sub.aluwb", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // R-type and
        set_in(7'b0110011, 3'b111, 1'b0, 1'b0);
        step();
        step();
        expect_cyc("and.exec", 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("and.aluctl", {29'd0, bus.ALUControl}, 32'd2);
        bus.funct3 = 3'b110;
        #1;
        chk("or.aluctl", {29'd0, bus.ALUControl}, 32'd3);
        bus.funct3 = 3'b100;
        #1;
        chk("xor.aluctl", {29'd0, bus.ALUControl}, 32'd4);
        step();
        step();

        // I-type addi with funct7b5 set stays add; slti
        set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
        step();
        step();
        expect_cyc("addi.exec", 4'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("addi.aluctl", {29'd0, bus.ALUControl}, 32'd0);
        chk("addi.srcB", {30'd0, bus.ALUSrcB}, 32'd1);
        bus.funct3 = 3'b010;
        #1;
        chk("slti.aluctl", {29'd0, bus.ALUControl}, 32'd5);
        step();
        expect_cyc("addi.aluwb", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // beq taken
        set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
        chk("beq.imm", {30'd0, bus.ImmSrc}, 32'd2);
        step();
        expect_cyc("beq1.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_cyc("beq1.br", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("beq1.aluctl", {29'd0, bus.ALUControl}, 32'd1);
        step();
        expect_cyc("beq1.after", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // beq not taken
        set_in(7'b1100011, 3'b000, 1'b0, 1'b0);
        step();
        step();
        expect_cyc("beq0.br", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        step();

        // bne encoding, Zero=0
        set_in(7'b1100011, 3'b001, 1'b0, 1'b0);
        step();
        step();
        expect_cyc("bne.br", 4'd9, exp_bne, 1'b0, 1'b0, 1'b0);
        step();

        // jal
        set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
        chk("jal.imm", {30'd0, bus.ImmSrc}, 32'd3);
        step();
        step();
        expect_cyc("jal.jal", 4'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("jal.srcA", {30'd0, bus.ALUSrcA}, 32'd1);
        step();
        expect_cyc("jal.aluwb", 4'd8, 1'b0, 1'b0, 1'b0, 1'b1);
        step();

        // unsupported opcode: two cycles, no writes in DECODE
        set_in(7'b1111111, 3'b000, 1'b0, 1'b1);
        step();
        expect_cyc("bad.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_cyc("bad.after", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);

        // reset asserted in MEMREAD
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        step();
        step();
        step();
        expect_cyc("rst2.memread", 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        expect_cyc("rst2.async", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_cyc("rst2.held", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        expect_cyc("rst2.release", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        expect_cyc("rst2.decode", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        expect_cyc("rst2.memadr", 4'd2, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for the 32-bit multicycle datapath.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 op  input  7  instruction opcode (Instr[6:0]), from the instruction register.
REQ-005 funct3  input  3  Instr[14:12].
REQ-006 funct7b5  input  1  Instr[30].
REQ-007 Zero  input  1  ALU equality flag; valid only while ALUControl=001.
REQ-008 PCWrite, IRWrite, MemWrite, RegWrite  output  1 each  datapath write enables.
REQ-009 AdrSrc  output  1  memory address select: 0=PC, 1=Result.
REQ-010 ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult.
REQ-011 ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1.
REQ-012 ALUSrcB  output  2  00=rs2, 01=ImmExt, 10=constant 4.
REQ-013 ImmSrc  output  2  00=I, 01=S, 10=B, 11=J.
REQ-014 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
REQ-015 state_dbg  output  4  current state encoding.

Function
REQ-016 The block SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-017 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1, and always advance to DECODE.
REQ-018 DECODE SHALL drive ALUSrcA=01, ALUSrcB=01, ALUOp=00 and branch on op: 0000011/0100011 to MEMADR, 0110011 to EXECUTER, 0010011 to EXECUTEI, 1100011 to BEQ, 1101111 to JAL, any other op to FETCH.
REQ-019 MEMADR SHALL drive ALUSrcA=10, ALUSrcB=01, ALUOp=00, then go to MEMREAD when op=0000011, else MEMWRITE.
REQ-020 MEMREAD SHALL drive ResultSrc=00, AdrSrc=1 and go to MEMWB; MEMWB SHALL drive ResultSrc=01, RegWrite=1 and go to FETCH.
REQ-021 MEMWRITE SHALL drive ResultSrc=00, AdrSrc=1, MemWrite=1 and go to FETCH.
REQ-022 EXECUTER (ALUSrcA=10, ALUSrcB=00) and EXECUTEI (ALUSrcA=10, ALUSrcB=01) SHALL drive ALUOp=10 and go to ALUWB; ALUWB SHALL drive ResultSrc=00, RegWrite=1 and go to FETCH.
REQ-023 BEQ SHALL drive ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 and go to FETCH.
REQ-024 JAL SHALL drive ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 and go to ALUWB.
REQ-025 Unlisted outputs SHALL be 0 in every state; PCWrite SHALL equal PCUpdate | (Branch & taken), where taken=Zero.
REQ-026 ALUControl SHALL be combinational: ALUOp 00 gives 000; ALUOp 01 gives 001; ALUOp 10 decodes funct3 000 as 001 when op[5]&funct7b5 (else 000), 010 as 101, 100 as 100, 110 as 011, 111 as 010, and any other funct3 as 000.
REQ-027 ImmSrc SHALL decode from op alone: 0100011 gives 01, 1100011 gives 10, 1101111 gives 11, all others 00.
REQ-028 Latency per instruction SHALL be: lw 5, sw 4, R/I-type 4, beq 3, jal 4 cycles; unsupported op 2 cycles.

Reset
REQ-029 rst_n low SHALL force state to FETCH immediately, independent of clk.
REQ-030 While rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0; other outputs SHALL show their FETCH values.
REQ-031 Reset asserted mid-instruction SHALL abandon it with no further write enables; the first rising edge after release executes FETCH.

Configuration
REQ-032 With MC_CTRL_BNE_EN defined, BEQ SHALL compute taken = funct3[0] ? ~Zero : Zero, supporting bne; without it, taken=Zero for any funct3.

Structure
REQ-033 A shared package SHALL hold the state enum, ALUOp and ALUControl codes, and opcode constants.
REQ-034 The ALUControl decode SHALL be a separate combinational sub-module named alu_dec.

Verification
REQ-035 Reset release, op=0000011 -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; RegWrite=1 only in MEMWB.
REQ-036 op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECUTER; funct3=111 -> 010.
REQ-037 op=1100011, Zero=1 -> PCWrite=1 in BEQ; Zero=0 -> PCWrite=0; with MC_CTRL_BNE_EN, funct3=001 and Zero=0 -> PCWrite=1.
REQ-038 op=0100011 -> MemWrite=1 for exactly one cycle in MEMWRITE, ImmSrc=01.
REQ-039 op=1111111 -> DECODE returns to FETCH with no write enables; rst_n pulsed low in MEMREAD -> state_dbg shows FETCH at once and all write enables stay 0.
